// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package qu_fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // kill sits in the LSB so the FIFO kill-all hook can set bit 0 of every entry
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic                  kill;
  } inflight_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and kill-all hook
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type T       = logic [7:0],
  parameter bit  KILL_EN = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       kill_all,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = $bits(T);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);

  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // a fresh push in the kill cycle writes after the kill and so stays live
  always_ff @(posedge clk) begin
    if (KILL_EN && kill_all) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i][0] <= 1'b1;
    end
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential PC generation, imem request tracking and fetch queue to decode
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FQ_DEPTH     = 4,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr
);

  import qu_fetch_pkg::*;

  localparam int FQ_CW = $clog2(FQ_DEPTH+1);
  localparam int TR_CW = $clog2(MAX_INFLIGHT+1);

  logic [XLEN-1:0]  pc_q;
  logic             credit_ok;
  logic             req_fire;
  logic             resp_keep;
  logic             dec_fire;

  inflight_entry_t  trk_push_data;
  inflight_entry_t  trk_head;
  logic             trk_empty;
  logic             trk_full;
  logic [TR_CW-1:0] inflight_cnt;

  fetch_entry_t     fq_push_data;
  fetch_entry_t     fq_head;
  logic             fq_empty;
  logic             fq_full;
  logic [FQ_CW-1:0] fq_count;

  // reserving a queue slot per outstanding request lets responses arrive unthrottled
  assign credit_ok = (int'(inflight_cnt) < MAX_INFLIGHT) &&
                     ((int'(inflight_cnt) + int'(fq_count)) < FQ_DEPTH);

  assign imem_req_valid = !rst && if_en && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && !trk_empty && !trk_head.kill && !redirect_valid;
  assign dec_valid = !fq_empty;
  assign dec_fire  = dec_valid && dec_ready && !redirect_valid;
  assign dec_pc    = fq_head.pc;
  assign dec_instr = fq_head.instr;

  assign trk_push_data = '{pc: pc_q, kill: 1'b0};
  assign fq_push_data  = '{pc: trk_head.pc, instr: imem_resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // in-flight requests survive a redirect so their responses can be matched and dropped
  fetch_fifo #(
    .DEPTH   (MAX_INFLIGHT),
    .T       (inflight_entry_t),
    .KILL_EN (1'b1)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .kill_all  (redirect_valid),
    .push      (req_fire),
    .push_data (trk_push_data),
    .pop       (imem_resp_valid),
    .head_data (trk_head),
    .empty     (trk_empty),
    .full      (trk_full),
    .count     (inflight_cnt)
  );

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .T       (fetch_entry_t),
    .KILL_EN (1'b0)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .kill_all  (1'b0),
    .push      (resp_keep),
    .push_data (fq_push_data),
    .pop       (dec_fire),
    .head_data (fq_head),
    .empty     (fq_empty),
    .full      (fq_full),
    .count     (fq_count)
  );

  a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> !trk_empty);

  a_tracker_no_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !trk_full);

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (resp_keep && fq_full) |-> dec_fire);

endmodule
